input_buffer: RTL and testbench
===============================

# input_buffer

Per-port input FIFO for the NOC router. Five instances (N, S, W, E, L) sit between the incoming links and the arbiter. Each instance stores incoming flits and presents the first-word-fall-through head flit to the crossbar. It gives the arbiter an empty flag and the 16-bit destination header of the packet at the head. Each flit popped by the arbiter returns one credit to the upstream router.

## Interface
Parameters:
- FLIT_W, 32, flit width in bits (≥16).
- DEPTH, 4, FIFO entries (power of two, ≥2); upstream credit counters are initialised to DEPTH.
- PKT_FLITS, 4, flits per packet (≥2); flit 0 is the header, and its bits [15:0] are the yx destination address.

Ports:
- clk  in  1  router clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ib_data_i  in  FLIT_W  incoming flit from the link.
- ib_valid_i  in  1  ib_data_i is valid this cycle; the upstream credit protocol guarantees no valid while full.
- ib_read_i  in  1  pop request from the arbiter (its per-port read output).
- ib_data_o  out  FLIT_W  head flit (FWFT), to the crossbar mux.
- ib_empty_o  out  1  FIFO holds no flits.
- ib_full_o  out  1  FIFO holds DEPTH flits.
- ib_addr_header_o  out  16  bits [15:0] of the most recent header flit to reach the head.
- ib_head_is_header_o  out  1  current head entry is a header flit.
- ib_credit_o  out  1  one-cycle credit-return pulse to upstream.
- ib_overflow_o  out  1  sticky error flag: a write arrived while full.

## Operation
- Storage: a DEPTH × (FLIT_W+1) register array. The extra bit tags header flits. Write and read pointers are each log2(DEPTH) bits and wrap naturally modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
- Write side: the accept condition is ib_valid_i & (~full | pop).
  - An accepted flit is stored at wr_ptr, and wr_ptr increments.
  - A write-side flit counter (0..PKT_FLITS-1) tags the flit as header when the counter is 0. The counter increments on each accepted write and wraps to 0 after PKT_FLITS-1.
- Overflow: ib_valid_i while full without a same-cycle pop drops the flit.
  - The flit counter does not advance.
  - ib_overflow_o sets and holds until reset.
- Pop: pop = ib_read_i & ~empty. The entry at rd_ptr is discarded and rd_ptr increments. ib_read_i while empty is ignored: no pointer change, no credit.
- Simultaneous push and pop: the occupancy counter is unchanged. This is legal when full (the freed slot is reused the same edge). When empty, only the push takes effect.
- Head outputs are combinational from the rd_ptr entry. ib_data_o is 0 when empty.
- ib_head_is_header_o is the tag bit of the head entry, or 0 when empty.
- Header register: updates whenever the head entry is a header and not empty. It otherwise holds, so the arbiter sees a stable destination for every body flit of the packet.
- Credit: ib_credit_o is registered and equals the pop signal from the previous cycle. There is exactly one pulse per popped flit.
- Flags: ib_empty_o = (count == 0); ib_full_o = (count == DEPTH).

## Timing
- Reset (reset low, asynchronous) clears the following immediately:
  - pointers, count and flit counter → 0;
  - ib_empty_o=1, ib_full_o=0;
  - ib_data_o=0, ib_addr_header_o=0, ib_head_is_header_o=0;
  - ib_credit_o=0, ib_overflow_o=0.
- Reset asserted mid-packet discards all stored flits and pending credit. After release, the next accepted flit is treated as a header.
- Write-to-head latency: 1 cycle. A flit accepted at edge k appears on ib_data_o with ib_empty_o=0 after edge k.
- Header register latency: updates at the edge after a header becomes head. ib_addr_header_o is valid one cycle after ib_empty_o deasserts for a new packet.
- Pop-to-credit latency: 1 cycle. A pop at edge k gives ib_credit_o high for the cycle following edge k.
- Throughput: one push and one pop per cycle sustained; full bandwidth with DEPTH ≥ 2.

## Test plan
- Reset, then 4 writes (PKT_FLITS=4) of 0x0000_0102, 0xA1, 0xA2, 0xA3:
  - ib_empty_o falls 1 cycle after the first write;
  - ib_head_is_header_o=1 at the head;
  - ib_addr_header_o=0x0102 on the next cycle;
  - ib_full_o=1 after the 4th write.
- Full FIFO with ib_read_i held for 4 cycles:
  - flits are output in order 0x102, 0xA1, 0xA2, 0xA3;
  - ib_credit_o pulses 4 times, each 1 cycle after its pop;
  - ib_addr_header_o stays 0x0102 throughout;
  - ib_empty_o=1 at the end.
- Full FIFO with simultaneous valid and read: the count stays 4, no overflow, and the new flit is the last popped. Valid without read while full: the flit is dropped, ib_overflow_o=1 and stays set.
- ib_read_i pulsed while empty: no ib_credit_o, pointers unchanged. Simultaneous write and read while empty: only the write is taken, ib_empty_o=0 on the next cycle.
- Pointer wrap: 12 flits (3 packets) streamed with continuous read. ib_addr_header_o takes each packet's header (e.g. 0x0102, 0x0201, 0x0303) in turn, and there is no loss or duplication.
- Reset asserted with 2 flits stored: outputs return to their reset values immediately with no clock edge. The first flit written after release is tagged as header.

Source files
------------

// File: rtl/input_buffer.sv
// input_buffer: per-port input FIFO for a NOC router.
//   Stores incoming flits and presents the head flit first-word-fall-through.
//   Each entry carries an extra tag bit that marks header flits.
//   The arbiter sees three things from this block:
//     - an empty flag;
//     - the 16-bit destination of the packet at the head;
//     - a one-cycle credit pulse for every flit it pops.
// Ports:
//   clk                  router clock, rising edge
//   reset                asynchronous active-low reset
//   ib_data_i/valid_i    incoming flit and its valid strobe
//   ib_read_i            pop request from the arbiter
//   ib_data_o            head flit (0 when empty)
//   ib_empty_o/full_o    occupancy flags
//   ib_addr_header_o     bits [15:0] of the latest header to reach the head
//   ib_head_is_header_o  head entry is a header flit
//   ib_credit_o          registered credit-return pulse (pop delayed 1 cycle)
//   ib_overflow_o        sticky: a write arrived while full without a pop
module input_buffer #(
  parameter int unsigned FLIT_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PKT_FLITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] ib_data_i,
  input  logic              ib_valid_i,
  input  logic              ib_read_i,
  output logic [FLIT_W-1:0] ib_data_o,
  output logic              ib_empty_o,
  output logic              ib_full_o,
  output logic [15:0]       ib_addr_header_o,
  output logic              ib_head_is_header_o,
  output logic              ib_credit_o,
  output logic              ib_overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FC_W  = $clog2(PKT_FLITS);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [FC_W-1:0]  LAST_FLIT = FC_W'(PKT_FLITS - 1);

  // Bit FLIT_W of each entry is the header tag.
  logic [FLIT_W:0]    mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FC_W-1:0]    flit_cnt_q, flit_cnt_d;
  logic [15:0]        hdr_q, hdr_d;
  logic               credit_q, credit_d;
  logic               ovf_q, ovf_d;

  logic               empty, full, push, pop;
  logic [FLIT_W:0]    head;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = ib_read_i & ~empty;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push  = ib_valid_i & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flit_cnt_d = flit_cnt_q;
    hdr_d      = hdr_q;
    credit_d   = pop;
    ovf_d      = ovf_q | (ib_valid_i & full & ~pop);

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      flit_cnt_d = (flit_cnt_q == LAST_FLIT) ? '0 : flit_cnt_q + FC_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Holds across body flits so the arbiter keeps a stable destination.
    if (!empty && head[FLIT_W]) begin
      hdr_d = head[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flit_cnt_q <= '0;
      hdr_q      <= '0;
      credit_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flit_cnt_q <= flit_cnt_d;
      hdr_q      <= hdr_d;
      credit_q   <= credit_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: every head output is gated by the empty flag.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {(flit_cnt_q == '0), ib_data_i};
    end
  end

  assign ib_data_o           = empty ? '0 : head[FLIT_W-1:0];
  assign ib_head_is_header_o = ~empty & head[FLIT_W];
  assign ib_empty_o          = empty;
  assign ib_full_o           = full;
  assign ib_addr_header_o    = hdr_q;
  assign ib_credit_o         = credit_q;
  assign ib_overflow_o       = ovf_q;

endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed self-checking bench for input_buffer
// (FLIT_W=32, DEPTH=4, PKT_FLITS=4).
module tb_input_buffer;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PKT_FLITS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] ib_data_i;
  logic              ib_valid_i;
  logic              ib_read_i;
  logic [FLIT_W-1:0] ib_data_o;
  logic              ib_empty_o;
  logic              ib_full_o;
  logic [15:0]       ib_addr_header_o;
  logic              ib_head_is_header_o;
  logic              ib_credit_o;
  logic              ib_overflow_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  input_buffer #(
    .FLIT_W   (FLIT_W),
    .DEPTH    (DEPTH),
    .PKT_FLITS(PKT_FLITS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ib_data_i          (ib_data_i),
    .ib_valid_i         (ib_valid_i),
    .ib_read_i          (ib_read_i),
    .ib_data_o          (ib_data_o),
    .ib_empty_o         (ib_empty_o),
    .ib_full_o          (ib_full_o),
    .ib_addr_header_o   (ib_addr_header_o),
    .ib_head_is_header_o(ib_head_is_header_o),
    .ib_credit_o        (ib_credit_o),
    .ib_overflow_o      (ib_overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pkt1 [4];
  logic [31:0] drain2 [4];
  logic [31:0] tail3 [3];
  logic [15:0] hdrs [3];
  logic [31:0] stream [12];
  int unsigned rcv;

  initial begin
    pkt1   = '{32'h0000_0102, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    drain2 = '{32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3, 32'h0000_0301};
    tail3  = '{32'h0000_00C1, 32'h0000_00C2, 32'h0000_00C3};
    hdrs   = '{16'h0102, 16'h0201, 16'h0303};
    for (int p = 0; p < 3; p++) begin
      stream[p*4] = {16'h0000, hdrs[p]};
      for (int b = 1; b < 4; b++) stream[p*4+b] = 32'hE000_0000 | 32'(p*16 + b);
    end

    reset      = 1'b0;
    ib_data_i  = '0;
    ib_valid_i = 1'b0;
    ib_read_i  = 1'b0;
    #1;
    check("rst_empty",  32'(ib_empty_o), 32'd1);
    check("rst_full",   32'(ib_full_o), 32'd0);
    check("rst_data",   ib_data_o, 32'd0);
    check("rst_hdr",    32'(ib_addr_header_o), 32'd0);
    check("rst_hih",    32'(ib_head_is_header_o), 32'd0);
    check("rst_credit", 32'(ib_credit_o), 32'd0);
    check("rst_ovf",    32'(ib_overflow_o), 32'd0);
    #2;
    reset = 1'b1;
    step;

    // Packet 1 fill.
    ib_valid_i = 1'b1;
    ib_data_i  = pkt1[0];
    step;
    check("w1_empty", 32'(ib_empty_o), 32'd0);
    check("w1_data",  ib_data_o, 32'h0000_0102);
    check("w1_hih",   32'(ib_head_is_header_o), 32'd1);
    check("w1_hdr",   32'(ib_addr_header_o), 32'd0);
    ib_data_i = pkt1[1];
    step;
    check("w2_hdr",   32'(ib_addr_header_o), 32'h0102);
    check("w2_full",  32'(ib_full_o), 32'd0);
    ib_data_i = pkt1[2];
    step;
    ib_data_i = pkt1[3];
    step;
    check("w4_full",  32'(ib_full_o), 32'd1);
    check("w4_credit", 32'(ib_credit_o), 32'd0);
    ib_valid_i = 1'b0;

    // Drain packet 1 with read held.
    ib_read_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("d1_data", ib_data_o, pkt1[i]);
      step;
      check("d1_credit", 32'(ib_credit_o), 32'd1);
      check("d1_hdr", 32'(ib_addr_header_o), 32'h0102);
    end
    ib_read_i = 1'b0;
    check("d1_empty", 32'(ib_empty_o), 32'd1);
    step;
    check("d1_credit_end", 32'(ib_credit_o), 32'd0);

    // Packet 2 fill, then push+pop while full, then a dropped write.
    ib_valid_i = 1'b1;
    ib_data_i  = 32'h0000_0201;
    step;
    for (int i = 0; i < 3; i++) begin
      ib_data_i = drain2[i];
      step;
    end
    check("p2_full", 32'(ib_full_o), 32'd1);
    check("p2_hdr",  32'(ib_addr_header_o), 32'h0201);
    ib_data_i = 32'h0000_0301;
    ib_read_i = 1'b1;
    step;
    check("pp_full",   32'(ib_full_o), 32'd1);
    check("pp_ovf",    32'(ib_overflow_o), 32'd0);
    check("pp_data",   ib_data_o, 32'h0000_00B1);
    check("pp_credit", 32'(ib_credit_o), 32'd1);
    ib_data_i = 32'h0000_0999;
    ib_read_i = 1'b0;
    step;
    check("ov_ovf",    32'(ib_overflow_o), 32'd1);
    check("ov_full",   32'(ib_full_o), 32'd1);
    check("ov_data",   ib_data_o, 32'h0000_00B1);
    check("ov_credit", 32'(ib_credit_o), 32'd0);
    ib_valid_i = 1'b0;
    ib_read_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("d2_data", ib_data_o, drain2[i]);
      check("d2_hih", 32'(ib_head_is_header_o), 32'(i == 3));
      step;
      check("d2_ovf", 32'(ib_overflow_o), 32'd1);
    end
    check("d2_empty", 32'(ib_empty_o), 32'd1);
    check("d2_hdr",   32'(ib_addr_header_o), 32'h0301);

    // Read while empty: no credit, no pointer movement.
    step;
    check("er_credit", 32'(ib_credit_o), 32'd0);
    check("er_empty",  32'(ib_empty_o), 32'd1);
    ib_read_i = 1'b0;
    step;
    // Simultaneous write and read while empty; dropped flit did not advance
    // the flit counter, so this is packet position 1 (body).
    ib_valid_i = 1'b1;
    ib_read_i  = 1'b1;
    ib_data_i  = tail3[0];
    step;
    check("ew_empty",  32'(ib_empty_o), 32'd0);
    check("ew_data",   ib_data_o, 32'h0000_00C1);
    check("ew_hih",    32'(ib_head_is_header_o), 32'd0);
    check("ew_credit", 32'(ib_credit_o), 32'd0);
    ib_read_i = 1'b0;
    ib_data_i = tail3[1];
    step;
    ib_data_i = tail3[2];
    step;
    ib_valid_i = 1'b0;
    ib_read_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("d3_data", ib_data_o, tail3[i]);
      step;
    end
    check("d3_empty", 32'(ib_empty_o), 32'd1);

    // Stream 3 packets through with read held (pointer wrap).
    rcv        = 0;
    ib_valid_i = 1'b1;
    for (int c = 0; c < 40 && rcv < 12; c++) begin
      if (c < 12) ib_data_i = stream[c];
      else        ib_valid_i = 1'b0;
      if (!ib_empty_o) begin
        check("st_data", ib_data_o, stream[rcv]);
        check("st_hih",  32'(ib_head_is_header_o), 32'(rcv % 4 == 0));
        if (rcv % 4 == 1) check("st_hdr", 32'(ib_addr_header_o), 32'(hdrs[rcv/4]));
        rcv++;
      end
      step;
    end
    ib_valid_i = 1'b0;
    ib_read_i  = 1'b0;
    check("st_count", rcv, 32'd12);
    check("st_empty", 32'(ib_empty_o), 32'd1);

    // Async reset with two flits stored.
    ib_valid_i = 1'b1;
    ib_data_i  = 32'h0000_0404;
    step;
    ib_data_i  = 32'h0000_00D1;
    step;
    ib_valid_i = 1'b0;
    step;
    check("pr_hdr", 32'(ib_addr_header_o), 32'h0404);
    #2;
    reset = 1'b0;
    #1;
    check("ar_empty",  32'(ib_empty_o), 32'd1);
    check("ar_full",   32'(ib_full_o), 32'd0);
    check("ar_data",   ib_data_o, 32'd0);
    check("ar_hdr",    32'(ib_addr_header_o), 32'd0);
    check("ar_hih",    32'(ib_head_is_header_o), 32'd0);
    check("ar_credit", 32'(ib_credit_o), 32'd0);
    check("ar_ovf",    32'(ib_overflow_o), 32'd0);
    reset      = 1'b1;
    ib_valid_i = 1'b1;
    ib_data_i  = 32'h0000_0505;
    step;
    check("pw_data", ib_data_o, 32'h0000_0505);
    check("pw_hih",  32'(ib_head_is_header_o), 32'd1);
    ib_valid_i = 1'b0;
    step;
    check("pw_hdr",  32'(ib_addr_header_o), 32'h0505);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
